// File: rtl/mips32_mem_reader_pkg.sv
// ============================================================================
// Module      : mips32_mem_reader_pkg
// Description : Shared types and constants for the MIPS32 memory readback engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips32_mem_reader_pkg;

    localparam int MEM_READER_FIFO_DEPTH = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_HALT = 3'd1,
        READ      = 3'd2,
        DRAIN     = 3'd3,
        DONE      = 3'd4
    } mem_reader_state_t;

endpackage

`default_nettype wire

// File: rtl/mips32_mem_reader_if.sv
// ============================================================================
// Module      : mips32_mem_reader_if
// Description : Memory read port and output stream of the readback engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips32_mem_reader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) ();
    import mips32_mem_reader_pkg::*;

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    modport master (
        output mem_rd_en, mem_rd_addr,
        input  mem_rd_data,
        output out_valid, out_data, out_addr, out_last,
        input  out_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr,
        output mem_rd_data,
        input  out_valid, out_data, out_addr, out_last,
        output out_ready
    );

endinterface

`default_nettype wire

// File: rtl/mips32_mem_reader_fifo.sv
// ============================================================================
// Module      : mem_reader_fifo
// Description : Small synchronous FIFO holding {last, addr, data} stream words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_reader_fifo
    import mips32_mem_reader_pkg::*;
#(
    parameter int WIDTH = 43
) (
    input  wire logic                                           clk,
    input  wire logic                                           rst_n,
    input  wire logic                                           push,
    input  wire logic [WIDTH-1:0]                               push_data,
    input  wire logic                                           pop,
    output logic      [WIDTH-1:0]                               pop_data,
    output logic      [$clog2(MEM_READER_FIFO_DEPTH+1)-1:0]     count
);
    localparam int c_ptr_w = $clog2(MEM_READER_FIFO_DEPTH);
    localparam int c_cnt_w = $clog2(MEM_READER_FIFO_DEPTH+1);

    logic [WIDTH-1:0]   r_mem [MEM_READER_FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_READER_FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;

endmodule

`default_nettype wire

// File: rtl/mips32_mem_reader.sv
// ============================================================================
// Module      : mips32_mem_reader
// Description : Streams a range of data-memory words out once the core halts.
//               Optional running checksum output under MEM_READER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips32_mem_reader
    import mips32_mem_reader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  wire logic              clk1,
    input  wire logic              rst_n,
    input  wire logic              halted,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] base_addr,
    input  wire logic [ADDR_W:0]   length,
    output logic                   busy,
    output logic                   done,
`ifdef MEM_READER_CHECKSUM_EN
    output logic [DATA_W-1:0]      checksum,
`endif
    mips32_mem_reader_if.master    bus
);
    localparam int              c_fifo_w = 1 + ADDR_W + DATA_W;
    localparam int              c_cnt_w  = $clog2(MEM_READER_FIFO_DEPTH+1);
    localparam logic [ADDR_W:0] c_one    = 1;

    mem_reader_state_t   r_state;
    mem_reader_state_t   w_next;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     r_issued;
    logic [ADDR_W:0]     r_emit;
    logic                r_inflight;
    logic                w_accept;
    logic                w_issue;
    logic                w_pop;
    logic [2:0]          w_occ;
    logic [c_cnt_w-1:0]  w_fifo_count;
    logic [c_fifo_w-1:0] w_push_data;
    logic [c_fifo_w-1:0] w_head;

    assign w_accept = (r_state == IDLE) && start;
    assign w_pop    = bus.out_valid && bus.out_ready;
    assign w_occ    = 3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue  = (r_state == READ) && (r_issued != r_len)
                      && (w_occ < 3'(MEM_READER_FIFO_DEPTH));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (start) w_next = WAIT_HALT;
            // An empty request passes through DRAIN so done keeps a fixed latency.
            WAIT_HALT: if (halted) w_next = (r_len == '0) ? DRAIN : READ;
            READ:      if (w_issue && (r_issued == r_len - c_one)) w_next = DRAIN;
            DRAIN:     if ((r_len == '0) || (w_pop && bus.out_last)) w_next = DONE;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_emit     <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_issue;
            if (w_accept) begin
                r_base   <= base_addr;
                r_len    <= length;
                r_issued <= '0;
                r_emit   <= '0;
            end else begin
                if (w_issue)    r_issued <= r_issued + c_one;
                if (r_inflight) r_emit   <= r_emit + c_one;
            end
        end
    end

    // Responses return in issue order, so the emit index also gives the address.
    assign w_push_data = {(r_emit == r_len - c_one),
                          r_base + r_emit[ADDR_W-1:0],
                          bus.mem_rd_data};

    mem_reader_fifo #(
        .WIDTH     (c_fifo_w)
    ) u_fifo (
        .clk       (clk1),
        .rst_n     (rst_n),
        .push      (r_inflight),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .count     (w_fifo_count)
    );

    assign bus.mem_rd_en   = w_issue;
    assign bus.mem_rd_addr = r_base + r_issued[ADDR_W-1:0];
    assign bus.out_valid   = (w_fifo_count != '0);
    assign bus.out_data    = w_head[DATA_W-1:0];
    assign bus.out_addr    = w_head[DATA_W +: ADDR_W];
    assign bus.out_last    = w_head[c_fifo_w-1];

    assign busy = (r_state == WAIT_HALT) || (r_state == READ) || (r_state == DRAIN);
    assign done = (r_state == DONE);

`ifdef MEM_READER_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum + bus.out_data;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips32_mem_reader.sv
// ============================================================================
// Module      : tb_mips32_mem_reader
// Description : Directed self-checking bench for mips32_mem_reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips32_mem_reader;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b1;
    logic        halted = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] length = '0;
    logic        busy;
    logic        done;
`ifdef MEM_READER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mips32_mem_reader_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    mips32_mem_reader #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .halted    (halted),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
`ifdef MEM_READER_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .bus       (bus)
    );

    always #5 clk1 = ~clk1;

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    logic [31:0] mem [0:1023];
    always @(posedge clk1) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
    end

    // Observation log, sampled mid-cycle.
    logic [9:0]  hs_addr_q [$];
    logic [31:0] hs_data_q [$];
    logic        hs_last_q [$];
    int          hs_cyc_q  [$];
    int          done_q    [$];
    int rd_cnt, first_rd_cyc, valid_cnt, first_valid_cyc, stall_err, max_occ, done_busy;
    logic        stalled = 1'b0;
    logic [9:0]  p_addr;
    logic [31:0] p_data;
    logic        p_last;

    task automatic clear_mon();
        hs_addr_q.delete(); hs_data_q.delete(); hs_last_q.delete(); hs_cyc_q.delete();
        done_q.delete();
        rd_cnt = 0; first_rd_cyc = -1; valid_cnt = 0; first_valid_cyc = -1;
        stall_err = 0; max_occ = 0; done_busy = 0;
    endtask

    always @(negedge clk1) begin
        if (rst_n) begin
            if (bus.mem_rd_en) begin
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                rd_cnt++;
            end
            if (rd_cnt - int'(hs_data_q.size()) > max_occ) max_occ = rd_cnt - int'(hs_data_q.size());
            if (bus.out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                valid_cnt++;
            end
            if (stalled && (!bus.out_valid || bus.out_data !== p_data ||
                            bus.out_addr !== p_addr || bus.out_last !== p_last)) stall_err++;
            stalled = bus.out_valid && !bus.out_ready;
            p_addr = bus.out_addr; p_data = bus.out_data; p_last = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                hs_addr_q.push_back(bus.out_addr);
                hs_data_q.push_back(bus.out_data);
                hs_last_q.push_back(bus.out_last);
                hs_cyc_q.push_back(cyc);
            end
            if (done) begin
                done_q.push_back(cyc);
                if (busy) done_busy++;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic start_xfer(input logic [9:0] b, input logic [10:0] l, output int t);
        @(posedge clk1); #1;
        base_addr = b; length = l; start = 1'b1; t = cyc;
        @(posedge clk1); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk1); #1;
            if (done_q.size() > 0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (bus.mem_rd_en !== 1'b0 || bus.mem_rd_addr !== 10'd0) begin n_errors++;
            $display("FAIL reset_rd: got en=%b addr=%0d want 0/0", bus.mem_rd_en, bus.mem_rd_addr); end
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_addr !== 10'd0 || bus.out_data !== 32'd0) begin n_errors++;
            $display("FAIL reset_out: got v=%b l=%b a=%0d d=%0d want all 0", bus.out_valid, bus.out_last, bus.out_addr, bus.out_data); end
        repeat (2) @(posedge clk1);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int t; bit ok;
        clear_mon(); halted = 1'b1; bus.out_ready = 1'b1;
        start_xfer(10'd120, 11'd2, t);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy_t1: got %b want 1", busy); end
        wait_done(40, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL basic_done_timeout: got none want done"); end
        n_checks++; if (first_rd_cyc !== t + 2) begin n_errors++; $display("FAIL basic_first_rd: got %0d want %0d", first_rd_cyc, t + 2); end
        n_checks++; if (first_valid_cyc !== t + 4) begin n_errors++; $display("FAIL basic_first_valid: got %0d want %0d", first_valid_cyc, t + 4); end
        n_checks++; if (hs_data_q.size() != 2) begin n_errors++; $display("FAIL basic_count: got %0d want 2", hs_data_q.size()); end
        else begin
            n_checks++; if (hs_addr_q[0] !== 10'd120 || hs_data_q[0] !== 32'd85 || hs_last_q[0] !== 1'b0) begin n_errors++;
                $display("FAIL basic_w0: got %0d/%0d/%b want 120/85/0", hs_addr_q[0], hs_data_q[0], hs_last_q[0]); end
            n_checks++; if (hs_addr_q[1] !== 10'd121 || hs_data_q[1] !== 32'd130 || hs_last_q[1] !== 1'b1) begin n_errors++;
                $display("FAIL basic_w1: got %0d/%0d/%b want 121/130/1", hs_addr_q[1], hs_data_q[1], hs_last_q[1]); end
            n_checks++; if (hs_cyc_q[1] !== hs_cyc_q[0] + 1) begin n_errors++; $display("FAIL basic_rate: got %0d want %0d", hs_cyc_q[1], hs_cyc_q[0] + 1); end
            n_checks++; if (ok && done_q[0] !== hs_cyc_q[1] + 1) begin n_errors++; $display("FAIL basic_done_cyc: got %0d want %0d", done_q[0], hs_cyc_q[1] + 1); end
        end
        n_checks++; if (done_busy != 0) begin n_errors++; $display("FAIL basic_busy_at_done: got busy=1 want 0"); end
        n_checks++; if (done_q.size() != 1) begin n_errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_q.size()); end
`ifdef MEM_READER_CHECKSUM_EN
        n_checks++; if (checksum !== 32'd215) begin n_errors++; $display("FAIL basic_checksum: got %0d want 215", checksum); end
`endif
    endtask

    task automatic test_wait_halt();
        int t, h; bit ok;
        clear_mon(); halted = 1'b0; bus.out_ready = 1'b1;
        start_xfer(10'd120, 11'd2, t);
        repeat (9) begin @(posedge clk1); #1; end
        n_checks++; if (rd_cnt != 0) begin n_errors++; $display("FAIL halt_no_early_rd: got %0d reads want 0", rd_cnt); end
        halted = 1'b1; h = cyc;
        repeat (2) begin @(posedge clk1); #1; end
        halted = 1'b0;
        wait_done(40, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL halt_done_timeout: got none want done"); end
        n_checks++; if (first_rd_cyc !== h + 1) begin n_errors++; $display("FAIL halt_first_rd: got %0d want %0d", first_rd_cyc, h + 1); end
        n_checks++; if (hs_data_q.size() != 2) begin n_errors++; $display("FAIL halt_count: got %0d want 2", hs_data_q.size()); end
        else begin
            n_checks++; if (hs_data_q[0] !== 32'd85 || hs_data_q[1] !== 32'd130 || hs_last_q[1] !== 1'b1) begin n_errors++;
                $display("FAIL halt_stream: got %0d,%0d last=%b want 85,130 last=1", hs_data_q[0], hs_data_q[1], hs_last_q[1]); end
        end
        halted = 1'b1;
    endtask

    task automatic test_wrap();
        int t; bit ok;
        logic [9:0]  exp_a [4] = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        logic [31:0] exp_d [4] = '{32'hA1, 32'hB2, 32'hC3, 32'hD4};
        clear_mon(); bus.out_ready = 1'b1;
        start_xfer(10'd1022, 11'd4, t);
        wait_done(40, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL wrap_done_timeout: got none want done"); end
        n_checks++; if (hs_data_q.size() != 4) begin n_errors++; $display("FAIL wrap_count: got %0d want 4", hs_data_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (hs_addr_q[i] !== exp_a[i] || hs_data_q[i] !== exp_d[i] || hs_last_q[i] !== (i == 3)) begin n_errors++;
                    $display("FAIL wrap_w%0d: got %0d/%h/%b want %0d/%h/%b", i, hs_addr_q[i], hs_data_q[i], hs_last_q[i], exp_a[i], exp_d[i], i == 3); end
            end
        end
    endtask

    task automatic test_backpressure();
        int t; bit ok;
        logic [3:0] pat = 4'b1001;
        clear_mon();
        start_xfer(10'd200, 11'd8, t);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            bus.out_ready = pat[k % 4];
            @(posedge clk1); #1;
            if (done_q.size() > 0) begin ok = 1'b1; break; end
        end
        bus.out_ready = 1'b1;
        n_checks++; if (!ok) begin n_errors++; $display("FAIL bp_done_timeout: got none want done"); end
        n_checks++; if (hs_data_q.size() != 8) begin n_errors++; $display("FAIL bp_count: got %0d want 8", hs_data_q.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (hs_addr_q[i] !== 10'(200 + i) || hs_data_q[i] !== 32'h1000 + 32'(i) || hs_last_q[i] !== (i == 7)) begin n_errors++;
                    $display("FAIL bp_w%0d: got %0d/%h/%b want %0d/%h/%b", i, hs_addr_q[i], hs_data_q[i], hs_last_q[i], 200 + i, 32'h1000 + 32'(i), i == 7); end
            end
        end
        n_checks++; if (stall_err != 0) begin n_errors++; $display("FAIL bp_stable: got %0d changes want 0", stall_err); end
        n_checks++; if (max_occ > 3) begin n_errors++; $display("FAIL bp_occupancy: got %0d want <=3", max_occ); end
    endtask

    task automatic test_len_zero();
        int t; bit ok;
        clear_mon(); bus.out_ready = 1'b1;
        start_xfer(10'd5, 11'd0, t);
        wait_done(20, ok);
        n_checks++; if (!ok || done_q[0] !== t + 3) begin n_errors++; $display("FAIL zero_done_cyc: got %0d want %0d", ok ? done_q[0] : -1, t + 3); end
        n_checks++; if (rd_cnt != 0) begin n_errors++; $display("FAIL zero_reads: got %0d want 0", rd_cnt); end
        n_checks++; if (valid_cnt != 0) begin n_errors++; $display("FAIL zero_valid: got %0d want 0", valid_cnt); end
    endtask

    task automatic test_reset_mid();
        int t; bit ok;
        clear_mon(); bus.out_ready = 1'b1;
        start_xfer(10'd300, 11'd6, t);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (hs_data_q.size() == 2) begin ok = 1'b1; break; end
            @(posedge clk1); #1;
        end
        n_checks++; if (!ok) begin n_errors++; $display("FAIL rmid_reach_w3: got %0d words want 2", hs_data_q.size()); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || bus.mem_rd_en !== 1'b0 || bus.mem_rd_addr !== 10'd0) begin n_errors++;
            $display("FAIL rmid_ctrl: got busy=%b done=%b en=%b addr=%0d want 0", busy, done, bus.mem_rd_en, bus.mem_rd_addr); end
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_addr !== 10'd0 || bus.out_data !== 32'd0) begin n_errors++;
            $display("FAIL rmid_out: got v=%b l=%b a=%0d d=%0d want 0", bus.out_valid, bus.out_last, bus.out_addr, bus.out_data); end
        @(posedge clk1); #1;
        rst_n = 1'b1;
        repeat (6) begin @(posedge clk1); #1; end
        n_checks++; if (done_q.size() != 0 || busy !== 1'b0) begin n_errors++;
            $display("FAIL rmid_no_done: got %0d done busy=%b want 0/0", done_q.size(), busy); end
        clear_mon();
        start_xfer(10'd120, 11'd2, t);
        wait_done(40, ok);
        n_checks++; if (!ok || hs_data_q.size() != 2) begin n_errors++; $display("FAIL rmid_restart: got done=%b words=%0d want 1/2", ok, hs_data_q.size()); end
        else begin
            n_checks++; if (hs_addr_q[1] !== 10'd121 || hs_data_q[0] !== 32'd85 || hs_data_q[1] !== 32'd130) begin n_errors++;
                $display("FAIL rmid_restart_data: got %0d,%0d@%0d want 85,130@121", hs_data_q[0], hs_data_q[1], hs_addr_q[1]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i) * 32'd3 + 32'd7;
        mem[120] = 32'd85; mem[121] = 32'd130;
        mem[1022] = 32'hA1; mem[1023] = 32'hB2; mem[0] = 32'hC3; mem[1] = 32'hD4;
        for (int i = 0; i < 8; i++) mem[200 + i] = 32'h1000 + 32'(i);
        for (int i = 0; i < 6; i++) mem[300 + i] = 32'h300 + 32'(i) * 32'd11;
        bus.out_ready = 1'b1;
        clear_mon();
        test_reset();
        test_basic();
        test_wait_halt();
        test_wrap();
        test_backpressure();
        test_len_zero();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
